// File: rtl/scr1_timer_mc_if.sv
// Shared memory-bus types and the DMEM-side interface of the multi-channel timer.
package scr1_timer_mc_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

// DMEM request/response bundle; the core side is the master, the timer the slave.
interface scr1_timer_mc_if;
    import scr1_timer_mc_pkg::*;

    logic                        req;
    type_scr1_mem_cmd_e          cmd;
    type_scr1_mem_width_e        width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata;
    logic                        req_ack;
    logic [31:0]                 rdata;
    type_scr1_mem_resp_e         resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/scr1_timer_mc.sv
// Multi-channel machine timer: one shared 64-bit mtime with prescaler and
// NUM_CH compare channels (one-shot or periodic), each with a sticky pending
// bit, an interrupt enable and its own interrupt line.
module scr1_timer_mc
    import scr1_timer_mc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    scr1_timer_mc_if.slave    dmem,
    output logic [63:0]       timer_val,
    output logic              timer_irq,
    output logic [NUM_CH-1:0] ch_irq
);
    // first byte offset past the last channel block
    localparam logic [8:0] CH_END = 9'(32 + 16 * NUM_CH);

    logic [7:0]           off;
    logic                 acc_ok;
    logic                 is_ch;
    logic [3:0]           ch_idx;
    logic                 wr;
    logic                 wr_ctrl;
    logic                 wr_div;
    logic                 wr_mtime_lo;
    logic                 wr_mtime_hi;
    logic                 wr_pend;
    logic                 wr_irq_en;
    logic [NUM_CH-1:0]    wr_ch;
    logic [31:0]          rd_val;
    logic                 unused_addr;

    logic                 en;
    logic [DIV_WIDTH-1:0] divider;
    logic [DIV_WIDTH-1:0] presc;
    logic                 tick;
    logic [63:0]          mtime_reg;
    logic [63:0]          mtime_nxt;

    logic [NUM_CH-1:0]    pend;
    logic [NUM_CH-1:0]    irq_en;
    logic [NUM_CH-1:0]    match;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    periodic;
    logic [63:0]          cmp_reg [NUM_CH];
    logic [31:0]          period  [NUM_CH];

    logic [31:0]          rdata_reg;
    type_scr1_mem_resp_e  resp_reg;

    assign off         = dmem.addr[7:0];
    assign unused_addr = ^dmem.addr[SCR1_DMEM_AWIDTH-1:8];
    assign is_ch       = (off >= 8'h20);
    assign ch_idx      = off[7:4] - 4'd2;

    // word-size, aligned, and inside a populated part of the map
    always_comb begin
        acc_ok = (dmem.width == SCR1_MEM_WIDTH_WORD) && (off[1:0] == 2'b00);
        if ((off >= 8'h18) && (off < 8'h20)) acc_ok = 1'b0;
        if ({1'b0, off} >= CH_END)           acc_ok = 1'b0;
    end

    assign wr          = dmem.req && acc_ok && (dmem.cmd == SCR1_MEM_CMD_WR);
    assign wr_ctrl     = wr && (off == 8'h00);
    assign wr_div      = wr && (off == 8'h04);
    assign wr_mtime_lo = wr && (off == 8'h08);
    assign wr_mtime_hi = wr && (off == 8'h0C);
    assign wr_pend     = wr && (off == 8'h10);
    assign wr_irq_en   = wr && (off == 8'h14);

    // read mux over the pre-edge register values
    always_comb begin
        rd_val = '0;
        if (is_ch) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (off[3:2])
                        2'd0:    rd_val = cmp_reg[c][31:0];
                        2'd1:    rd_val = cmp_reg[c][63:32];
                        2'd2:    rd_val = {30'd0, periodic[c], ch_en[c]};
                        default: rd_val = period[c];
                    endcase
                end
            end
        end else begin
            case (off[4:2])
                3'd0:    rd_val = {31'd0, en};
                3'd1:    rd_val = 32'(divider);
                3'd2:    rd_val = mtime_reg[31:0];
                3'd3:    rd_val = mtime_reg[63:32];
                3'd4:    rd_val = 32'(pend);
                3'd5:    rd_val = 32'(irq_en);
                default: rd_val = '0;
            endcase
        end
    end

    assign tick = en && (presc == '0);

    // a half written in the same cycle as a tick keeps wdata, the other half still advances
    always_comb begin
        mtime_nxt = tick ? (mtime_reg + 64'd1) : mtime_reg;
        if (wr_mtime_lo) mtime_nxt[31:0]  = dmem.wdata;
        if (wr_mtime_hi) mtime_nxt[63:32] = dmem.wdata;
    end

    // enable, prescaler and the shared time base
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en        <= 1'b1;
            divider   <= '0;
            presc     <= '0;
            mtime_reg <= '0;
        end else begin
            if (wr_ctrl) en <= dmem.wdata[0];
            if (wr_div) begin
                divider <= dmem.wdata[DIV_WIDTH-1:0];
                presc   <= dmem.wdata[DIV_WIDTH-1:0];
            end else if (tick) begin
                presc <= divider;
            end else if (en) begin
                presc <= presc - DIV_WIDTH'(1);
            end
            mtime_reg <= mtime_nxt;
        end
    end

    // pending bits are sticky; a new match beats a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend   <= '0;
            irq_en <= '0;
        end else begin
            if (wr_irq_en) irq_en <= dmem.wdata[NUM_CH-1:0];
            pend <= (wr_pend ? (pend & ~dmem.wdata[NUM_CH-1:0]) : pend) | match;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [63:0] cmp_ch;
        logic [63:0] cmp_nxt;
        logic [31:0] period_ch;
        logic        en_ch;
        logic        mode_ch;

        assign wr_ch[c]   = wr && is_ch && (ch_idx == 4'(c));
        assign match[c]   = en_ch && (mtime_reg >= cmp_ch);
        assign cmp_reg[c] = cmp_ch;
        assign period[c]  = period_ch;
        assign ch_en[c]   = en_ch;
        assign periodic[c] = mode_ch;

        // periodic reload first, then a bus write to either half overrides that half
        always_comb begin
            cmp_nxt = (match[c] && mode_ch) ? (cmp_ch + {32'd0, period_ch}) : cmp_ch;
            if (wr_ch[c] && (off[3:2] == 2'd0)) cmp_nxt[31:0]  = dmem.wdata;
            if (wr_ch[c] && (off[3:2] == 2'd1)) cmp_nxt[63:32] = dmem.wdata;
        end

        // per-channel compare, mode and reload registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cmp_ch    <= '1;
                period_ch <= '0;
                en_ch     <= 1'b0;
                mode_ch   <= 1'b0;
            end else begin
                cmp_ch <= cmp_nxt;
                if (wr_ch[c] && (off[3:2] == 2'd2)) begin
                    en_ch   <= dmem.wdata[0];
                    mode_ch <= dmem.wdata[1];
                end else if (match[c] && !mode_ch) begin
                    en_ch <= 1'b0;
                end
                if (wr_ch[c] && (off[3:2] == 2'd3)) period_ch <= dmem.wdata;
            end
        end
    end

    // registered bus response, one cycle after the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_reg  <= SCR1_MEM_RESP_NOTRDY;
            rdata_reg <= '0;
        end else if (dmem.req) begin
            resp_reg  <= acc_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
            rdata_reg <= (acc_ok && (dmem.cmd == SCR1_MEM_CMD_RD)) ? rd_val : 32'd0;
        end else begin
            resp_reg  <= SCR1_MEM_RESP_NOTRDY;
            rdata_reg <= '0;
        end
    end

    assign dmem.req_ack = 1'b1;
    assign dmem.rdata   = rdata_reg;
    assign dmem.resp    = resp_reg;

    assign timer_val = mtime_reg;
    assign ch_irq    = pend & irq_en;
    assign timer_irq = |(pend & irq_en);
endmodule

// File: doc/scr1_timer_mc.md
# scr1_timer_mc

Multi-channel memory-mapped machine timer for the SCR1 core, the parametrised successor of the single-compare timer. It provides one shared 64-bit `mtime` counter with a programmable prescaler and `NUM_CH` independent compare channels, each with one-shot or periodic auto-reload mode. Each channel has a sticky pending bit, a per-channel interrupt enable and its own interrupt line. The block sits on the DMEM bus and feeds `timer_val`/`timer_irq` to the core and `ch_irq` to the platform interrupt controller.

## Interface
- `NUM_CH`, 4, number of compare channels (1..8)
- `DIV_WIDTH`, 16, prescaler divider width (1..32)
- `clk`  in  1  the single block clock
- `rst`  in  1  asynchronous, active-high reset
- `dmem_req`  in  1  access request
- `dmem_cmd`  in  1  `SCR1_MEM_CMD_RD` / `SCR1_MEM_CMD_WR`
- `dmem_width`  in  `type_scr1_mem_width_e`  access width
- `dmem_addr`  in  `SCR1_DMEM_AWIDTH`  byte address; only bits [7:0] are decoded
- `dmem_wdata`  in  `SCR1_DMEM_DWIDTH`  write data
- `dmem_req_ack`  out  1  constant 1
- `dmem_rdata`  out  32  registered read data
- `dmem_resp`  out  `type_scr1_mem_resp_e`  registered response
- `timer_val`  out  64  current `mtime`
- `timer_irq`  out  1  OR of (`pend` & `irq_en`)
- `ch_irq`  out  `NUM_CH`  per-channel `pend` & `irq_en`

## Operation
- Register map (word offsets; access must be word width and word aligned):
  - 0x00 CONTROL: bit0 EN, reset 1
  - 0x04 DIVIDER: [DIV_WIDTH-1:0], reset 0
  - 0x08 MTIMELO, 0x0C MTIMEHI: reset 0
  - 0x10 PEND: read value; writing 1 to a bit clears it (W1C)
  - 0x14 IRQ_EN: [NUM_CH-1:0], reset 0
  - 0x20+16·c CMPLO, +4 CMPHI: reset all ones
  - +8 CH_CTRL: bit0 CH_EN, bit1 PERIODIC; reset 0
  - +C PERIOD: 32-bit, zero-extended reload increment; reset 0
- Unused bits read 0. Offsets 0x18–0x1F, offsets at or beyond 0x20+16·NUM_CH, sub-word width and misalignment are errors: `RDY_ER`, no state change.
- Prescaler: `presc` counts down while EN=1. `tick` = EN & (`presc`==0). On `tick`, `presc` reloads DIVIDER and `mtime` increments by 1 (64-bit wrap). A DIVIDER write also loads `presc` with the written value. DIVIDER=0 gives one tick per cycle; DIVIDER=N gives one tick per N+1 cycles. EN=0 freezes both `presc` and `mtime`.
- Channel match: `match[c]` = CH_EN & (`mtime_reg` >= `cmp_reg[c]`), unsigned 64-bit. On a match:
  - `pend[c]` sets.
  - PERIODIC=1: `cmp[c]` <= `cmp[c]` + PERIOD (64-bit wrap).
  - PERIODIC=0: CH_EN clears (one-shot).
- Simultaneous events:
  - Set and W1C of the same `pend` bit in one cycle: set wins.
  - CMP or CH_CTRL write and a match in one cycle: the match uses pre-write values. The written value wins over the reload or CH_EN clear. `pend` still sets.
  - MTIME half write and tick in one cycle: the written half takes wdata, the other half takes the incremented value.
- PERIOD=0 in periodic mode: the channel re-matches every cycle and `pend` re-sets immediately after each clear. This is legal.

## Timing
- `dmem_req_ack`=1 always. The response is registered and appears in the cycle after `dmem_req`.
- With no request: `dmem_resp`=`NOTRDY`, `dmem_rdata`=0.
- Writes take effect at the request edge. A read returns register values from before that edge.
- Match to `pend`/`ch_irq`/`timer_irq` is one cycle: the edge after `mtime_reg` >= `cmp_reg`.
- The periodic reload of `cmp` lands on the same edge as the `pend` set.
- Reset asserted (any time, including mid-access):
  - `dmem_resp`=`NOTRDY`, `dmem_rdata`=0, all IRQ outputs 0, `timer_val`=0.
  - All registers return to their reset values; `presc`=0.

## Test plan
- Reset, then read CONTROL/DIVIDER/MTIMELO/CMPLO ch0 -> 0x1, 0x0, small count, 0xFFFFFFFF, each `RDY_OK` one cycle after the request.
- DIVIDER=3, EN=1, MTIME=0 -> `mtime` increments every 4 clk; after 40 cycles MTIMELO reads 10±1.
- Ch1: CMP=20, PERIOD=10, PERIODIC=1, IRQ_EN[1]=1 -> `ch_irq[1]` rises at `mtime`=20. W1C PEND=0x2 -> the IRQ drops, then re-rises at `mtime`=30. CMPLO reads 40 after the second match.
- Ch0 one-shot, CMP=5 -> PEND[0] sets and CH_CTRL reads 0. After a W1C, no further IRQ at any later `mtime`.
- W1C of PEND[2] issued in the same cycle ch2 matches -> PEND[2] stays 1. A byte-width read or a read at 0x18 -> `RDY_ER`, no state change.
- Assert `rst` mid-write to CMPHI -> all outputs return to reset values next cycle and CMPHI reads 0xFFFFFFFF.
